// File: rtl/mips_result_checker_pkg.sv
// Shared types and constants for the MIPS result checker.
// Status codes, checker FSM states and a saturating counter helper.
package mips_result_checker_pkg;

    localparam int STATUS_W = 2;

    localparam logic [STATUS_W-1:0] R_TYPE        = 2'd0;
    localparam logic [STATUS_W-1:0] I_TYPE        = 2'd1;
    localparam logic [STATUS_W-1:0] MIPS_OVERFLOW = 2'd2;
    localparam logic [STATUS_W-1:0] MIPS_END      = 2'd3;

    typedef enum logic [1:0] {
        CHK_RUN,
        CHK_SCAN,
        CHK_DRAIN,
        CHK_DONE
    } chk_state_e;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v,
        input logic        en
    );
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/mips_result_checker_if.sv
// Status stream, golden lookup and memory-scan bus of the result checker.
// master = checker side, slave = core/golden-memory side.
interface mips_result_checker_if #(
    parameter int STATUS_W   = 2,
    parameter int STATUS_NUM = 88,
    parameter int MEM_SIZE   = 64,
    parameter int DATA_W     = 32
);
    localparam int IDX_W  = $clog2(STATUS_NUM + 1);
    localparam int ADDR_W = $clog2(MEM_SIZE);
    localparam int MERR_W = $clog2(MEM_SIZE + 1);

    logic [STATUS_W-1:0] i_status;
    logic                i_status_valid;
    logic [IDX_W-1:0]    o_gold_idx;
    logic [STATUS_W-1:0] i_gold_status;
    logic [ADDR_W-1:0]   o_mem_addr;
    logic                o_mem_re;
    logic [DATA_W-1:0]   i_dut_word;
    logic [DATA_W-1:0]   i_gold_word;
    logic [15:0]         o_stat_err_cnt;
    logic [MERR_W-1:0]   o_mem_err_cnt;
    logic                o_timeout;
    logic                o_done;
    logic                o_pass;

    modport master (
        input  i_status, i_status_valid, i_gold_status,
        input  i_dut_word, i_gold_word,
        output o_gold_idx, o_mem_addr, o_mem_re,
        output o_stat_err_cnt, o_mem_err_cnt,
        output o_timeout, o_done, o_pass
    );

    modport slave (
        output i_status, i_status_valid, i_gold_status,
        output i_dut_word, i_gold_word,
        input  o_gold_idx, o_mem_addr, o_mem_re,
        input  o_stat_err_cnt, o_mem_err_cnt,
        input  o_timeout, o_done, o_pass
    );

endinterface

// File: rtl/mips_result_checker_mem_scan_cmp.sv
// Memory scan: walks word addresses while i_scan is high and compares
// the DUT/golden words returned one cycle later.
module mem_scan_cmp #(
    parameter int MEM_SIZE = 64,
    parameter int DATA_W   = 32,
    localparam int ADDR_W  = $clog2(MEM_SIZE),
    localparam int MERR_W  = $clog2(MEM_SIZE + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scan,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_last,
    input  logic [DATA_W-1:0] i_dut_word,
    input  logic [DATA_W-1:0] i_gold_word,
    output logic [MERR_W-1:0] o_err_cnt,
    output logic              o_hit
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmp_q;
    logic [MERR_W-1:0] err_q, err_d;
    logic              last;
    logic              hit;

    always_comb begin
        last   = i_scan && (addr_q == ADDR_LAST);
        addr_d = (i_scan && !last) ? addr_q + ADDR_W'(1) : addr_q;
        // 4-state compare so X on either word counts as a mismatch
        hit    = cmp_q && (i_dut_word !== i_gold_word);
        err_d  = err_q + MERR_W'(hit);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= '0;
            cmp_q  <= 1'b0;
            err_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cmp_q  <= i_scan;
            err_q  <= err_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_re   = i_scan;
    assign o_last     = last;
    assign o_err_cnt  = err_q;
    assign o_hit      = hit;

endmodule

// File: rtl/mips_result_checker.sv
// Self-check block: compares the core status stream to a golden table,
// scans data memory on termination and reports done/pass/timeout.
module mips_result_checker #(
    parameter int STATUS_W   = 2,
    parameter int STATUS_NUM = 88,
    parameter int MEM_SIZE   = 64,
    parameter int DATA_W     = 32,
    parameter int MAX_CYCLE  = 120000,
    parameter int ST_OVF     = 2,
    parameter int ST_END     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mips_result_checker_if.master bus
);
    import mips_result_checker_pkg::*;

    localparam int IDX_W  = $clog2(STATUS_NUM + 1);
    localparam int ADDR_W = $clog2(MEM_SIZE);
    localparam int MERR_W = $clog2(MEM_SIZE + 1);
    localparam int CYC_W  = $clog2(MAX_CYCLE + 1);

    localparam logic [IDX_W-1:0]    IDX_NUM  = IDX_W'(STATUS_NUM);
    localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(MAX_CYCLE - 1);
    localparam logic [STATUS_W-1:0] END_C    = STATUS_W'(ST_END);
    localparam logic [STATUS_W-1:0] OVF_C    = STATUS_W'(ST_OVF);

    chk_state_e        state_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       serr_q, serr_d;
    logic [CYC_W-1:0]  cyc_q;
    logic              timeout_q;
    logic              done_q;
    logic              pass_q;

    logic              in_range;
    logic              term;
    logic              stat_hit;
    logic              scan_en;
    logic              scan_last;
    logic              mem_hit;
    logic [MERR_W-1:0] merr;
    logic [ADDR_W-1:0] addr;
    logic              mem_re;

    always_comb begin
        in_range = idx_q < IDX_NUM;
        term     = bus.i_status_valid &&
                   ((bus.i_status === END_C) || (bus.i_status === OVF_C));
        // Overrun of the golden table is itself a mismatch
        stat_hit = bus.i_status_valid &&
                   (!in_range || (bus.i_status !== bus.i_gold_status));
        idx_d    = (bus.i_status_valid && in_range) ? idx_q + IDX_W'(1)
                                                    : idx_q;
        serr_d   = sat_inc16(serr_q, stat_hit);
    end

    assign scan_en = (state_q == CHK_SCAN);

    mem_scan_cmp #(
        .MEM_SIZE (MEM_SIZE),
        .DATA_W   (DATA_W)
    ) u_scan (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scan      (scan_en),
        .o_mem_addr  (addr),
        .o_mem_re    (mem_re),
        .o_last      (scan_last),
        .i_dut_word  (bus.i_dut_word),
        .i_gold_word (bus.i_gold_word),
        .o_err_cnt   (merr),
        .o_hit       (mem_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CHK_RUN;
            idx_q     <= '0;
            serr_q    <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            unique case (state_q)
                CHK_RUN: begin
                    cyc_q  <= cyc_q + CYC_W'(1);
                    idx_q  <= idx_d;
                    serr_q <= serr_d;
                    // Terminal status on the last budget cycle beats timeout
                    if (term) begin
                        state_q <= CHK_SCAN;
                    end else if (cyc_q == CYC_LAST) begin
                        state_q   <= CHK_DONE;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                CHK_SCAN: begin
                    if (scan_last) state_q <= CHK_DRAIN;
                end
                CHK_DRAIN: begin
                    state_q <= CHK_DONE;
                    done_q  <= 1'b1;
                    pass_q  <= (serr_q == 16'd0) && (merr == '0) &&
                               !mem_hit && !timeout_q &&
                               (idx_q == IDX_NUM);
                end
                CHK_DONE: begin
                    state_q <= CHK_DONE;
                end
                default: begin
                    state_q <= CHK_RUN;
                end
            endcase
        end
    end

    assign bus.o_gold_idx     = idx_q;
    assign bus.o_mem_addr     = addr;
    assign bus.o_mem_re       = mem_re;
    assign bus.o_stat_err_cnt = serr_q;
    assign bus.o_mem_err_cnt  = merr;
    assign bus.o_timeout      = timeout_q;
    assign bus.o_done         = done_q;
    assign bus.o_pass         = pass_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Bench for mips_result_checker: directed and random runs against a
// timeline model of the status compare, memory scan and verdict.
module tb_mips_result_checker;

    localparam int SN = 4;
    localparam int MS = 4;
    localparam int MC = 50;
    localparam int NC = 128;

    logic clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 clk = ~clk;

    mips_result_checker_if #(
        .STATUS_W(2), .STATUS_NUM(SN), .MEM_SIZE(MS), .DATA_W(32)
    ) bus ();

    mips_result_checker #(
        .STATUS_W(2), .STATUS_NUM(SN), .MEM_SIZE(MS), .DATA_W(32),
        .MAX_CYCLE(MC), .ST_OVF(2), .ST_END(3)
    ) dut (
        .i_clk (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // Golden status table, memories and per-cycle stimulus plan
    logic [1:0]  gold_tab [SN];
    logic [31:0] dmem [MS];
    logic [31:0] gmem [MS];
    logic        pv [NC];
    logic [1:0]  ps [NC];

    // Expected output timeline
    int e_idx [NC], e_serr [NC], e_merr [NC], e_addr [NC];
    bit e_re [NC], e_done [NC], e_pass [NC], e_tmo [NC];
    int run_len;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int first_done, first_merr;
    bit saw_re;

    always_comb begin
        bus.i_gold_status = (bus.o_gold_idx < 3'd4) ?
                            gold_tab[bus.o_gold_idx[1:0]] : 2'b00;
    end

    initial begin
        bus.i_dut_word  = '0;
        bus.i_gold_word = '0;
    end

    always @(posedge clk) begin
        if (bus.o_mem_re === 1'b1) begin
            bus.i_dut_word  <= dmem[bus.o_mem_addr];
            bus.i_gold_word <= gmem[bus.o_mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Timeline: k-th valid is compared to gold_tab[k]; the first terminal
    // status at cycle t opens MS scan cycles, one drain cycle, then done.
    task automatic build_expect();
        int k, serr, t, d, mtot, m;
        k = 0; serr = 0; t = -1; mtot = 0;
        for (int j = 0; j < MS; j++)
            if (dmem[j] !== gmem[j]) mtot++;
        for (int c = 0; c < NC; c++) begin
            e_idx[c] = 0; e_serr[c] = 0; e_merr[c] = 0; e_addr[c] = 0;
            e_re[c] = 0; e_done[c] = 0; e_pass[c] = 0; e_tmo[c] = 0;
        end
        for (int c = 0; c < MC; c++) begin
            e_idx[c] = k;
            e_serr[c] = serr;
            if (pv[c] === 1'b1) begin
                if (k < SN) begin
                    if (ps[c] !== gold_tab[k]) serr++;
                    k++;
                end else begin
                    serr++;
                end
                if (ps[c] === 2'd2 || ps[c] === 2'd3) begin
                    t = c;
                    break;
                end
            end
        end
        d = (t < 0) ? MC : t + MS + 2;
        run_len = d + 3;
        for (int c = (t < 0) ? MC : t + 1; c < run_len; c++) begin
            e_idx[c]  = k;
            e_serr[c] = serr;
            e_re[c]   = (t >= 0) && (c <= t + MS);
            e_addr[c] = c - t - 1;
            m = 0;
            for (int j = 0; j < MS; j++)
                if (t >= 0 && t + 3 + j <= c && dmem[j] !== gmem[j]) m++;
            e_merr[c] = m;
            e_done[c] = (c >= d);
            e_tmo[c]  = (t < 0) && (c >= d);
            e_pass[c] = (c >= d) && (t >= 0) && (serr == 0) &&
                        (mtot == 0) && (k == SN);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gold_idx", 32'(bus.o_gold_idx), e_idx[cyc]);
            chk("stat_err", 32'(bus.o_stat_err_cnt), e_serr[cyc]);
            chk("mem_err", 32'(bus.o_mem_err_cnt), e_merr[cyc]);
            chk("mem_re", 32'(bus.o_mem_re), 32'(e_re[cyc]));
            if (e_re[cyc])
                chk("mem_addr", 32'(bus.o_mem_addr), e_addr[cyc]);
            chk("done", 32'(bus.o_done), 32'(e_done[cyc]));
            chk("pass", 32'(bus.o_pass), 32'(e_pass[cyc]));
            chk("timeout", 32'(bus.o_timeout), 32'(e_tmo[cyc]));
            if (bus.o_done === 1'b1 && first_done < 0) first_done = cyc;
            if (bus.o_mem_err_cnt !== '0 && first_merr < 0) first_merr = cyc;
            if (bus.o_mem_re === 1'b1) saw_re = 1'b1;
        end
    end

    task automatic run(input int rst_at);
        build_expect();
        bus.i_status_valid = 1'b0;
        bus.i_status = 2'b00;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        first_done = -1;
        first_merr = -1;
        saw_re = 1'b0;
        cyc = 0;
        chk_en = 1'b1;
        for (int c = 0; c < run_len; c++) begin
            cyc = c;
            bus.i_status_valid = pv[c];
            bus.i_status = ps[c];
            if (c == rst_at) i_rst = 1'b1;
            @(posedge clk);
            #1;
            if (c == rst_at) break;
        end
        chk_en = 1'b0;
        i_rst = 1'b0;
        bus.i_status_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_plan();
        for (int c = 0; c < NC; c++) begin
            pv[c] = 1'b0;
            ps[c] = 2'b00;
        end
    endtask

    task automatic put(input int c, input logic [1:0] s);
        pv[c] = 1'b1;
        ps[c] = s;
    endtask

    task automatic same_mem();
        for (int j = 0; j < MS; j++) begin
            gmem[j] = $urandom;
            dmem[j] = gmem[j];
        end
    endtask

    task automatic plan_t1();
        gold_tab[0] = 2'd0; gold_tab[1] = 2'd1;
        gold_tab[2] = 2'd0; gold_tab[3] = 2'd3;
        clear_plan();
        put(1, 2'd0); put(2, 2'd1); put(4, 2'd0); put(6, 2'd3);
    endtask

    task automatic rand_plan();
        int k, mode;
        for (int i = 0; i < SN - 1; i++) gold_tab[i] = 2'($urandom_range(0, 1));
        gold_tab[SN-1] = 2'($urandom_range(0, 3));
        mode = $urandom_range(0, 9);
        k = 0;
        clear_plan();
        for (int c = 0; c < NC; c++) begin
            if (mode != 0 && $urandom_range(0, 2) == 0) begin
                pv[c] = 1'b1;
                if (k < SN && $urandom_range(0, 4) != 0) ps[c] = gold_tab[k];
                else ps[c] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) ps[c] = 2'bxx;
                k++;
            end
        end
        for (int j = 0; j < MS; j++) begin
            gmem[j] = $urandom;
            dmem[j] = ($urandom_range(0, 3) == 0) ? $urandom : gmem[j];
            if ($urandom_range(0, 29) == 0) gmem[j] = 'x;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_status_valid = 1'b0;
        bus.i_status = 2'b00;
        clear_plan();
        same_mem();
        gold_tab[0] = 2'd0; gold_tab[1] = 2'd0;
        gold_tab[2] = 2'd0; gold_tab[3] = 2'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_pass", 32'(bus.o_pass), 32'd0);
        chk("rst_idx", 32'(bus.o_gold_idx), 32'd0);
        chk("rst_re", 32'(bus.o_mem_re), 32'd0);

        // 1: matching run, 4th valid at cycle 6 -> done at 12
        plan_t1(); same_mem(); run(-1);
        chk("t1_done_cyc", 32'(first_done), 32'd12);
        chk("t1_pass", 32'(bus.o_pass), 32'd1);
        chk("t1_serr", 32'(bus.o_stat_err_cnt), 32'd0);
        chk("t1_merr", 32'(bus.o_mem_err_cnt), 32'd0);

        // 2: one wrong status
        plan_t1(); ps[2] = 2'd0; same_mem(); run(-1);
        chk("t2_serr", 32'(bus.o_stat_err_cnt), 32'd1);
        chk("t2_pass", 32'(bus.o_pass), 32'd0);
        chk("t2_scanned", 32'(saw_re), 32'd1);

        // 3: word 2 differs
        plan_t1(); same_mem(); gmem[2] = 32'd5; dmem[2] = 32'd6; run(-1);
        chk("t3_merr", 32'(bus.o_mem_err_cnt), 32'd1);
        chk("t3_merr_cyc", 32'(first_merr), 32'd11);
        chk("t3_pass", 32'(bus.o_pass), 32'd0);

        // 4: no terminal status -> timeout
        plan_t1(); clear_plan(); put(3, 2'd0); put(9, 2'd1); run(-1);
        chk("t4_done_cyc", 32'(first_done), 32'd50);
        chk("t4_timeout", 32'(bus.o_timeout), 32'd1);
        chk("t4_no_re", 32'(saw_re), 32'd0);
        chk("t4_pass", 32'(bus.o_pass), 32'd0);

        // 5a: overflow as the final golden entry, extra valids ignored
        gold_tab[0] = 2'd0; gold_tab[1] = 2'd1;
        gold_tab[2] = 2'd0; gold_tab[3] = 2'd2;
        clear_plan();
        put(0, 2'd0); put(3, 2'd1); put(5, 2'd0); put(8, 2'd2);
        put(9, 2'd3); put(10, 2'd1); put(13, 2'd3);
        same_mem(); run(-1);
        chk("t5_done_cyc", 32'(first_done), 32'd14);
        chk("t5_pass", 32'(bus.o_pass), 32'd1);
        chk("t5_idx", 32'(bus.o_gold_idx), 32'd4);

        // 5b: overflow at idx 1 leaves golden table unconsumed
        gold_tab[1] = 2'd2;
        clear_plan(); put(2, 2'd0); put(3, 2'd2); put(6, 2'd0);
        same_mem(); run(-1);
        chk("t5b_idx", 32'(bus.o_gold_idx), 32'd2);
        chk("t5b_serr", 32'(bus.o_stat_err_cnt), 32'd0);
        chk("t5b_pass", 32'(bus.o_pass), 32'd0);

        // 6: reset while o_mem_addr=1, then rerun
        plan_t1(); same_mem(); run(8);
        chk("t6_idx", 32'(bus.o_gold_idx), 32'd0);
        chk("t6_serr", 32'(bus.o_stat_err_cnt), 32'd0);
        chk("t6_merr", 32'(bus.o_mem_err_cnt), 32'd0);
        chk("t6_re", 32'(bus.o_mem_re), 32'd0);
        chk("t6_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("t6_done", 32'(bus.o_done), 32'd0);
        chk("t6_pass", 32'(bus.o_pass), 32'd0);
        chk("t6_tmo", 32'(bus.o_timeout), 32'd0);
        plan_t1(); same_mem(); run(-1);
        chk("t6_rerun_pass", 32'(bus.o_pass), 32'd1);

        for (int r = 0; r < 40; r++) begin
            rand_plan();
            run(-1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
